// File: rtl/digital_port.sv
// digital_port: WIDTH-bit bidirectional GPIO port.
// Holds an output-value register and a direction register (1 = drive the pin,
// 0 = leave it high-impedance). Driven bits read back the register value;
// input bits read the pin.
// Build option: define DIGITAL_PORT_SYNC_EN to pass input pins through a
// two-flop synchronizer before readback. Without it, input readback is
// combinational from the pins.
module digital_port #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipSelect,
    input  logic             writeIO,
    input  logic             writeDirection,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] direction,
    inout  wire  [WIDTH-1:0] IO
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] pin_in;

    // Next-state for both registers; one strobe or both may load the same dataIn.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (chipSelect) begin
            if (writeIO)        out_d = dataIn;
            if (writeDirection) dir_d = dataIn;
        end
    end

    // Register update; reset wins over any concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            dir_q <= '0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

    // Per-pin tristate driver; outReg keeps its value while a bit is an input.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign IO[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

`ifdef DIGITAL_PORT_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-flop synchronizer on the raw pin values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= IO;
            sync2_q <= sync1_q;
        end
    end

    assign pin_in = sync2_q;
`else
    assign pin_in = IO;
`endif

    // Readback: register value for driven bits, pin sample for input bits.
    always_comb begin
        dataOut   = (dir_q & out_q) | (~dir_q & pin_in);
        direction = dir_q;
    end

endmodule

// File: tb/tb_digital_port.sv
// Bench for digital_port: directed scenarios followed by random bus/pin traffic,
// every cycle compared against a register-level reference model.
module tb_digital_port;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         chipSelect;
    logic         writeIO;
    logic         writeDirection;
    logic [W-1:0] dataIn;
    logic [W-1:0] dataOut;
    logic [W-1:0] direction;
    wire  [W-1:0] IO;

    // External pin driver: drives only bits the model says are inputs.
    logic [W-1:0] ext_val;
    logic [W-1:0] ext_en;

    // Reference model state.
    logic [W-1:0] m_out;
    logic [W-1:0] m_dir;
    logic [W-1:0] m_hist1;
    logic [W-1:0] m_hist2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ext_en = ~m_dir;

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign IO[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    digital_port #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .chipSelect     (chipSelect),
        .writeIO        (writeIO),
        .writeDirection (writeDirection),
        .dataIn         (dataIn),
        .dataOut        (dataOut),
        .direction      (direction),
        .IO             (IO)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cs, input logic wio,
                         input logic wd, input logic [W-1:0] d);
        reset          = r;
        chipSelect     = cs;
        writeIO        = wio;
        writeDirection = wd;
        dataIn         = d;
    endtask

    // Pin value seen by input readback: immediate, or the value present two edges ago.
    function automatic logic [W-1:0] pin_seen();
`ifdef DIGITAL_PORT_SYNC_EN
        return m_hist2;
`else
        return ext_val;
`endif
    endfunction

    // One clock: advance the model at the rising edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_out   = '0;
            m_dir   = '0;
            m_hist1 = '0;
            m_hist2 = '0;
        end else begin
            m_hist2 = m_hist1;
            m_hist1 = ext_val;
            if (chipSelect && writeIO)        m_out = dataIn;
            if (chipSelect && writeDirection) m_dir = dataIn;
        end
        @(negedge clk);
        chk("direction", direction, m_dir);
        chk("dataOut",   dataOut,   (m_dir & m_out) | (~m_dir & pin_seen()));
        chk("io_driven", IO & m_dir,  m_out & m_dir);
        chk("io_input",  IO & ~m_dir, ext_val & ~m_dir);
    endtask

    initial begin
        m_out   = '0;
        m_dir   = '0;
        m_hist1 = '0;
        m_hist2 = '0;
        ext_val = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) step();
        chk("reset_dir", direction, 32'h0);

        // Pins driven externally after reset; port must not drive any bit.
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        ext_val = 32'hA5A5_A5A5;
        repeat (3) step();
        chk("in_a5", dataOut, 32'hA5A5_A5A5);

        // Low byte made output, then written.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00FF);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
        step();
        chk("dir_ff",    direction,        32'h0000_00FF);
        chk("io_low78",  {24'h0, IO[7:0]}, 32'h0000_0078);
        chk("rd_low78",  {24'h0, dataOut[7:0]}, 32'h0000_0078);

        // Write with chip select low is ignored.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (2) step();
        chk("cs_low_io", {24'h0, IO[7:0]}, 32'h0000_0078);
        chk("cs_low_dir", direction, 32'h0000_00FF);

        // Both strobes together load the same word.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_F00F);
        step();
        chk("both_dir", direction, 32'h0000_F00F);
        chk("both_io",  IO & 32'h0000_F00F, 32'h0000_F00F);

        // outReg retained while input, then driven when direction flips.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1);
        ext_val = 32'h0;
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1);
        step();
        chk("flip_io0", {31'h0, IO[0]}, 32'h1);

        // Reset overrides a concurrent write.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step();
        chk("rst_wr_dir", direction, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom());
            if ($urandom_range(0, 1) == 1) ext_val = $urandom();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digital_port.md
DIGITAL_PORT -- requirements
Module: digital_port

Interface
REQ-001 Parameter WIDTH, default 32, number of port pins and width of every data bus below.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 chipSelect  input  1  port selected by bus decoder; writes ignored when low.
REQ-005 writeIO  input  1  write dataIn to output-value register.
REQ-006 writeDirection  input  1  write dataIn to direction register.
REQ-007 dataIn  input  WIDTH  write data from bus.
REQ-008 dataOut  output  WIDTH  per-pin read value.
REQ-009 direction  output  WIDTH  current direction register; 1 = output, 0 = input.
REQ-010 IO  inout  WIDTH  physical pins.

Function
REQ-011 Two state registers SHALL exist: outReg[WIDTH-1:0] and dirReg[WIDTH-1:0].
REQ-012 On a rising edge with reset low, chipSelect=1 and writeIO=1, outReg SHALL load dataIn.
REQ-013 On a rising edge with reset low, chipSelect=1 and writeDirection=1, dirReg SHALL load dataIn.
REQ-014 writeIO and writeDirection both high with chipSelect=1 SHALL update both registers from the same dataIn in the same cycle.
REQ-015 chipSelect=0 SHALL leave both registers unchanged regardless of writeIO, writeDirection, dataIn.
REQ-016 Write latency: new register value SHALL be visible on direction, IO and dataOut on the cycle after the write edge.
REQ-017 For each bit i: IO[i] SHALL be driven with outReg[i] when dirReg[i]=1 and SHALL be high-impedance when dirReg[i]=0.
REQ-018 For each bit i with dirReg[i]=1, dataOut[i] SHALL equal outReg[i] (register readback, not pin value).
REQ-019 For each bit i with dirReg[i]=0, dataOut[i] SHALL equal the input sample of IO[i] as defined in Configuration.
REQ-020 direction SHALL equal dirReg combinationally.
REQ-021 outReg content SHALL be retained while a bit is an input; switching dirReg[i] 0->1 SHALL immediately drive the previously written outReg[i].
REQ-022 No read side effects: dataOut SHALL not depend on chipSelect or write strobes.

Reset
REQ-023 While reset=1 at a rising edge, outReg and dirReg SHALL clear to 0, overriding any concurrent write.
REQ-024 After reset all pins SHALL be high-impedance, direction SHALL be 0, dataOut SHALL reflect pin inputs only.
REQ-025 Input synchronizer flops (when present) SHALL clear to 0 on reset.

Configuration
REQ-026 Macro DIGITAL_PORT_SYNC_EN defined: each input bit SHALL pass through a two-flop synchronizer; input-bit dataOut SHALL reflect IO two rising edges after pin change.
REQ-027 Macro DIGITAL_PORT_SYNC_EN undefined: input-bit dataOut SHALL be combinational from IO (zero latency); no synchronizer flops.

Verification
REQ-028 Reset, then external driver applies IO=0xA5A5A5A5 -> direction=0, port not driving, dataOut=0xA5A5A5A5 (after 2 edges with DIGITAL_PORT_SYNC_EN, immediately without).
REQ-029 chipSelect=1, writeDirection=1, dataIn=0x000000FF; then writeIO=1, dataIn=0x12345678 -> direction=0x000000FF, IO[7:0]=0x78, IO[31:8]=Z, dataOut[7:0]=0x78.
REQ-030 writeIO=1, dataIn=0xFFFFFFFF with chipSelect=0 -> outReg, IO and dataOut unchanged.
REQ-031 Simultaneous writeIO=1, writeDirection=1, dataIn=0x0000F00F -> next cycle direction=0x0000F00F, IO[15:12]=0xF, IO[3:0]=0xF, other bits Z.
REQ-032 Write outReg=0x1 with dir=0, then dir=0x1 -> IO[0] driven 1 next cycle; reset asserted together with a write of 0xFFFFFFFF -> both registers 0, all pins Z.
